// File: rtl/piece_spawn_hold.sv
// Spawn/hold controller between the seven-bag next-piece queue and the game FSM.
// Ports: clk/rst_l; game_clear, spawn_req, hold_req, queue_head in; pieces_remove,
//   spawn_valid, spawn_type, hold_type, hold_used, busy, queue_stall out (all registered).

package piece_spawn_hold_pkg;
  typedef enum logic [2:0] {
    BLANK  = 3'd0,
    TILE_I = 3'd1,
    TILE_O = 3'd2,
    TILE_T = 3'd3,
    TILE_S = 3'd4,
    TILE_Z = 3'd5,
    TILE_J = 3'd6,
    TILE_L = 3'd7
  } tile_type_t;
endpackage

module piece_spawn_hold
  import piece_spawn_hold_pkg::*;
#(
  parameter int HOLD_EN    = 1,
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       game_clear,
  input  logic       spawn_req,
  input  logic       hold_req,
  input  tile_type_t queue_head,
  output logic       pieces_remove,
  output logic       spawn_valid,
  output tile_type_t spawn_type,
  output tile_type_t hold_type,
  output logic       hold_used,
  output logic       busy,
  output logic       queue_stall
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam bit HOLD_ON = (HOLD_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_Q,
    S_DRAW,
    S_SWAP,
    S_ACTIVE
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic head_ok;
  logic hold_ok;

  assign head_ok = (queue_head != BLANK);
  assign hold_ok = HOLD_ON && hold_req && !hold_used;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= S_IDLE;
      spawn_type    <= BLANK;
      hold_type     <= BLANK;
      hold_used     <= 1'b0;
      pieces_remove <= 1'b0;
      spawn_valid   <= 1'b0;
      busy          <= 1'b0;
      queue_stall   <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      // Pulses are single-cycle: only the branches entering DRAW/SWAP raise them.
      pieces_remove <= 1'b0;
      spawn_valid   <= 1'b0;
      if (game_clear) begin
        state       <= S_IDLE;
        spawn_type  <= BLANK;
        hold_type   <= BLANK;
        hold_used   <= 1'b0;
        busy        <= 1'b0;
        queue_stall <= 1'b0;
        wait_cnt    <= '0;
      end else begin
        case (state)
          S_IDLE, S_ACTIVE: begin
            if (spawn_req) begin
              // A fresh drop re-arms hold; a simultaneous hold_req is dropped.
              hold_used <= 1'b0;
              busy      <= 1'b1;
              if (head_ok) begin
                spawn_type    <= queue_head;
                spawn_valid   <= 1'b1;
                pieces_remove <= 1'b1;
                state         <= S_DRAW;
              end else begin
                state <= S_WAIT_Q;
              end
            end else if (state == S_ACTIVE && hold_ok) begin
              hold_used <= 1'b1;
              busy      <= 1'b1;
              if (hold_type == BLANK) begin
                // Empty slot: park the falling piece and draw a new one.
                hold_type <= spawn_type;
                if (head_ok) begin
                  spawn_type    <= queue_head;
                  spawn_valid   <= 1'b1;
                  pieces_remove <= 1'b1;
                  state         <= S_DRAW;
                end else begin
                  state <= S_WAIT_Q;
                end
              end else begin
                // Exchange falling and held piece; queue untouched.
                spawn_type  <= hold_type;
                hold_type   <= spawn_type;
                spawn_valid <= 1'b1;
                state       <= S_SWAP;
              end
            end
          end
          S_WAIT_Q: begin
            if (head_ok) begin
              spawn_type    <= queue_head;
              spawn_valid   <= 1'b1;
              pieces_remove <= 1'b1;
              wait_cnt      <= '0;
              state         <= S_DRAW;
            end else begin
              // Counter saturates; stall flags on the WAIT_LIMIT-th blank cycle.
              if (wait_cnt != CW'(WAIT_LIMIT)) wait_cnt <= wait_cnt + CW'(1);
              if (wait_cnt >= CW'(WAIT_LIMIT - 1)) queue_stall <= 1'b1;
            end
          end
          S_DRAW, S_SWAP: begin
            state <= S_ACTIVE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piece_spawn_hold.sv
// Randomised + directed bench for piece_spawn_hold against a behavioural model.
// Ports: drives both a HOLD_EN=1 instance (fully modelled) and a HOLD_EN=0 instance.
// Summary line reports total checks and errors.

module tb_piece_spawn_hold;
  import piece_spawn_hold_pkg::*;

  localparam int LIMIT = 16;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       game_clear = 1'b0;
  logic       spawn_req = 1'b0;
  logic       hold_req = 1'b0;
  tile_type_t queue_head = BLANK;

  logic       pieces_remove, spawn_valid, hold_used, busy, queue_stall;
  tile_type_t spawn_type, hold_type;
  logic       n_pieces_remove, n_spawn_valid, n_hold_used, n_busy, n_queue_stall;
  tile_type_t n_spawn_type, n_hold_type;

  piece_spawn_hold #(.HOLD_EN(1), .WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_l(rst_l), .game_clear(game_clear), .spawn_req(spawn_req),
    .hold_req(hold_req), .queue_head(queue_head), .pieces_remove(pieces_remove),
    .spawn_valid(spawn_valid), .spawn_type(spawn_type), .hold_type(hold_type),
    .hold_used(hold_used), .busy(busy), .queue_stall(queue_stall)
  );

  piece_spawn_hold #(.HOLD_EN(0), .WAIT_LIMIT(LIMIT)) dut_nohold (
    .clk(clk), .rst_l(rst_l), .game_clear(game_clear), .spawn_req(spawn_req),
    .hold_req(hold_req), .queue_head(queue_head), .pieces_remove(n_pieces_remove),
    .spawn_valid(n_spawn_valid), .spawn_type(n_spawn_type), .hold_type(n_hold_type),
    .hold_used(n_hold_used), .busy(n_busy), .queue_stall(n_queue_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model. mode: 0 idle, 1 waiting for queue, 2 one-cycle spawn/swap, 3 falling.
  int m_mode, m_spawn, m_hold, m_used, m_valid, m_remove, m_stall, m_blank_cycles;
  int prev_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_spawn = 0; m_hold = 0; m_used = 0;
    m_valid = 0; m_remove = 0; m_stall = 0; m_blank_cycles = 0;
    prev_valid = 0;
  endtask

  // New falling piece from the queue head, or wait if the head is empty.
  task automatic model_take(input int head);
    if (head != 0) begin
      m_spawn = head; m_valid = 1; m_remove = 1; m_mode = 2;
    end else begin
      m_mode = 1;
    end
  endtask

  task automatic model_step(input bit sr, input bit hr, input bit gc, input int head);
    m_valid = 0; m_remove = 0;
    if (gc) begin
      m_mode = 0; m_spawn = 0; m_hold = 0; m_used = 0; m_stall = 0; m_blank_cycles = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (sr) begin
        m_used = 0;
        model_take(head);
      end else if (m_mode == 3 && hr && m_used == 0) begin
        m_used = 1;
        if (m_hold == 0) begin
          m_hold = m_spawn;
          model_take(head);
        end else begin
          int t;
          t = m_spawn; m_spawn = m_hold; m_hold = t;
          m_valid = 1; m_mode = 2;
        end
      end
    end else if (m_mode == 1) begin
      if (head != 0) begin
        m_blank_cycles = 0;
        model_take(head);
      end else begin
        m_blank_cycles++;
        if (m_blank_cycles >= LIMIT) m_stall = 1;
      end
    end else begin
      m_mode = 3;
    end
  endtask

  task automatic compare_all();
    check("spawn_valid", spawn_valid, m_valid);
    check("pieces_remove", pieces_remove, m_remove);
    check("spawn_type", spawn_type, m_spawn);
    check("hold_type", hold_type, m_hold);
    check("hold_used", hold_used, m_used);
    check("busy", busy, (m_mode == 1 || m_mode == 2));
    check("queue_stall", queue_stall, m_stall);
    check("inv_valid_twice", spawn_valid && prev_valid, 0);
    check("inv_remove_wo_valid", pieces_remove && !spawn_valid, 0);
    check("inv_valid_blank", spawn_valid && (spawn_type == BLANK), 0);
    check("nohold_hold_type", n_hold_type, BLANK);
    check("nohold_hold_used", n_hold_used, 0);
    prev_valid = spawn_valid;
  endtask

  task automatic drive(input bit sr, input bit hr, input bit gc, input tile_type_t head);
    spawn_req = sr; hold_req = hr; game_clear = gc; queue_head = head;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(spawn_req, hold_req, game_clear, int'(queue_head));
    compare_all();
  endtask

  initial begin
    bit starve;
    model_reset();
    #12;
    compare_all();
    rst_l = 1'b1;

    // 1: head blank three cycles, then T.
    drive(1, 0, 0, BLANK); tick();
    check("t1_busy", busy, 1);
    drive(0, 0, 0, BLANK); tick(); tick();
    drive(0, 0, 0, TILE_T); tick();
    check("t1_draw_valid", spawn_valid, 1);
    check("t1_draw_remove", pieces_remove, 1);
    check("t1_draw_type", spawn_type, TILE_T);
    drive(0, 0, 0, TILE_O); tick();
    check("t1_active_busy", busy, 0);

    // 2: hold into empty slot, then a refused second hold.
    drive(0, 1, 0, TILE_O); tick();
    check("t2_hold_type", hold_type, TILE_T);
    check("t2_spawn_type", spawn_type, TILE_O);
    check("t2_remove", pieces_remove, 1);
    drive(0, 0, 0, TILE_Z); tick();
    drive(0, 1, 0, TILE_Z); tick();
    check("t2_refused_valid", spawn_valid, 0);
    check("t2_refused_hold", hold_type, TILE_T);

    // 3: new drop re-arms hold; hold then swaps.
    drive(1, 0, 0, TILE_Z); tick();
    check("t3_spawn_z", spawn_type, TILE_Z);
    check("t3_used_clr", hold_used, 0);
    drive(0, 0, 0, TILE_L); tick();
    drive(0, 1, 0, TILE_L); tick();
    check("t3_swap_spawn", spawn_type, TILE_T);
    check("t3_swap_hold", hold_type, TILE_Z);
    check("t3_swap_valid", spawn_valid, 1);
    check("t3_swap_remove", pieces_remove, 0);
    drive(0, 0, 0, TILE_L); tick();

    // 4: spawn L, then spawn_req and hold_req together.
    drive(1, 0, 0, TILE_L); tick();
    drive(0, 0, 0, TILE_S); tick();
    drive(1, 1, 0, TILE_S); tick();
    check("t4_spawn_s", spawn_type, TILE_S);
    check("t4_hold_kept", hold_type, TILE_Z);
    check("t4_used", hold_used, 0);
    drive(0, 0, 0, BLANK); tick();

    // 5: starved queue raises sticky stall; game_clear wipes everything.
    drive(1, 0, 0, BLANK); tick();
    drive(0, 0, 0, BLANK);
    for (int i = 0; i < LIMIT - 1; i++) tick();
    check("t5_stall_early", queue_stall, 0);
    tick();
    check("t5_stall_set", queue_stall, 1);
    tick(); tick();
    drive(0, 0, 0, TILE_I); tick();
    check("t5_stall_sticky", queue_stall, 1);
    drive(0, 0, 1, TILE_J); tick();
    check("t5_clr_stall", queue_stall, 0);
    check("t5_clr_spawn", spawn_type, BLANK);
    check("t5_clr_hold", hold_type, BLANK);
    drive(0, 0, 0, TILE_J); tick();
    check("t5_no_pulse", spawn_valid, 0);

    // 6: async reset during DRAW.
    drive(1, 0, 0, TILE_I); tick();
    check("t6_in_draw", spawn_valid, 1);
    rst_l = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1;
    rst_l = 1'b1;
    drive(0, 0, 0, BLANK);

    // Randomised traffic with occasional starvation stretches.
    starve = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tile_type_t h;
      if (c % 64 == 0) starve = ($urandom_range(0, 3) == 0);
      if (starve ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) == 0))
        h = BLANK;
      else
        h = tile_type_t'(3'($urandom_range(1, 7)));
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 2, h);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
